// File: rtl/comb_vec_checker_pkg.sv
// Shared types and default sizes for the comb_vec_checker stimulus/compare stage.
// Feature macro: STOP_ON_FAIL_EN (end the sweep on the first mismatch).
package comb_chk_pkg;

    localparam int N_IN_DEF  = 3;
    localparam int N_VEC_DEF = 8;
    localparam int CW_DEF    = $clog2(N_VEC_DEF + 1);
    localparam int SETTLE_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/comb_vec_checker_if.sv
// Control, table-load and result signals of comb_vec_checker.
// master = controlling host, slave = checker.
interface comb_vec_checker_if
    import comb_chk_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int CW   = CW_DEF
);
    logic            start;
    logic            tbl_we;
    logic [N_IN-1:0] tbl_addr;
    logic            tbl_din;
    logic            busy;
    logic            done;
    logic            res_valid;
    logic [N_IN-1:0] res_idx;
    logic            res_got;
    logic            res_exp;
    logic            res_ok;
    logic [CW-1:0]   pass_cnt;
    logic [CW-1:0]   fail_cnt;
    logic            first_fail_vld;
    logic [N_IN-1:0] first_fail_idx;

    modport master (
        output start, tbl_we, tbl_addr, tbl_din,
        input  busy, done, res_valid, res_idx, res_got, res_exp, res_ok,
               pass_cnt, fail_cnt, first_fail_vld, first_fail_idx
    );

    modport slave (
        input  start, tbl_we, tbl_addr, tbl_din,
        output busy, done, res_valid, res_idx, res_got, res_exp, res_ok,
               pass_cnt, fail_cnt, first_fail_vld, first_fail_idx
    );
endinterface

// File: rtl/comb_exp_table.sv
// Expected-output table: N_VEC x 1 register file, one write port,
// one combinational read port, cleared by reset.
module comb_exp_table
    import comb_chk_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_VEC = N_VEC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [N_IN-1:0] waddr,
    input  logic            wdin,
    input  logic [N_IN-1:0] raddr,
    output logic            rdata
);
    logic [N_VEC-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdin;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/comb_vec_checker.sv
// Sweeps all input vectors of a 3-in/1-out combinational block and compares
// its output against a loadable table. Feature macro: STOP_ON_FAIL_EN.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   DRIVE  | put idx on x_out, load settle counter
//   WAIT   | let the block settle, count down
//   SAMPLE | capture f_in, compare, update counters
//   DONE   | run finished, results held until next start
module comb_vec_checker
    import comb_chk_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_VEC  = N_VEC_DEF,
    parameter int SETTLE = 2,
    parameter int CW     = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    comb_vec_checker_if.slave    bus,
    output logic [N_IN-1:0]      x_out,
    input  logic                 f_in
);
    state_t              state, state_nxt;
    logic [N_IN-1:0]     idx;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                exp_bit;
    logic                mismatch;
    logic                last_vec;
    logic                busy;

    logic                res_valid, res_got, res_exp, res_ok;
    logic [N_IN-1:0]     res_idx;
    logic [CW-1:0]       pass_cnt, fail_cnt;
    logic                first_fail_vld;
    logic [N_IN-1:0]     first_fail_idx;

    assign busy     = (state == DRIVE) || (state == WAIT) || (state == SAMPLE);
    assign mismatch = (f_in != exp_bit);
    assign last_vec = (idx == N_IN'(N_VEC - 1));

    // Table is frozen while a run is in progress.
    comb_exp_table #(.N_IN(N_IN), .N_VEC(N_VEC)) u_tbl (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bus.tbl_we && !busy),
        .waddr (bus.tbl_addr),
        .wdin  (bus.tbl_din),
        .raddr (idx),
        .rdata (exp_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = DRIVE;
            DRIVE:      state_nxt = WAIT;
            WAIT:       if (settle_cnt <= SETTLE_W'(1)) state_nxt = SAMPLE;
            SAMPLE: begin
`ifdef STOP_ON_FAIL_EN
                if (last_vec || mismatch) state_nxt = DONE;
`else
                if (last_vec) state_nxt = DONE;
`endif
                else state_nxt = DRIVE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= '0;
            settle_cnt     <= '0;
            x_out          <= '0;
            res_valid      <= 1'b0;
            res_idx        <= '0;
            res_got        <= 1'b0;
            res_exp        <= 1'b0;
            res_ok         <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        idx            <= '0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                    end
                end
                DRIVE: begin
                    x_out      <= idx;
                    settle_cnt <= SETTLE_W'(SETTLE);
                end
                WAIT: settle_cnt <= settle_cnt - SETTLE_W'(1);
                SAMPLE: begin
                    res_valid <= 1'b1;
                    res_idx   <= idx;
                    res_got   <= f_in;
                    res_exp   <= exp_bit;
                    res_ok    <= !mismatch;
                    if (mismatch) begin
                        fail_cnt <= fail_cnt + CW'(1);
                        if (!first_fail_vld) begin
                            first_fail_vld <= 1'b1;
                            first_fail_idx <= idx;
                        end
                    end else begin
                        pass_cnt <= pass_cnt + CW'(1);
                    end
                    if (!last_vec) idx <= idx + N_IN'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = busy;
    assign bus.done           = (state == DONE);
    assign bus.res_valid      = res_valid;
    assign bus.res_idx        = res_idx;
    assign bus.res_got        = res_got;
    assign bus.res_exp        = res_exp;
    assign bus.res_ok         = res_ok;
    assign bus.pass_cnt       = pass_cnt;
    assign bus.fail_cnt       = fail_cnt;
    assign bus.first_fail_vld = first_fail_vld;
    assign bus.first_fail_idx = first_fail_idx;
endmodule

// File: tb/tb_comb_vec_checker.sv
// Bench for comb_vec_checker: directed scenarios plus randomized tables,
// checked against a truth-table reference model. Honours STOP_ON_FAIL_EN.
module tb_comb_vec_checker;
    import comb_chk_pkg::*;

    localparam int N_IN   = 3;
    localparam int N_VEC  = 8;
    localparam int SETTLE = 2;
    localparam int CW     = 4;
    localparam int LAT    = SETTLE + 2;
`ifdef STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_IN-1:0] x_out;
    logic            f_in;
    logic [7:0]      dut_tt;
    logic [7:0]      model_tbl;
    int              checks = 0;
    int              failures = 0;

    comb_vec_checker_if #(.N_IN(N_IN), .CW(CW)) bus ();

    comb_vec_checker #(.N_IN(N_IN), .N_VEC(N_VEC), .SETTLE(SETTLE), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .x_out (x_out),
        .f_in  (f_in)
    );

    always #5 clk = ~clk;

    // Model of the combinational block under test.
    assign f_in = dut_tt[x_out];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_done"},  bus.done, 0);
        chk({tag, "_rv"},    bus.res_valid, 0);
        chk({tag, "_pass"},  bus.pass_cnt, 0);
        chk({tag, "_fail"},  bus.fail_cnt, 0);
        chk({tag, "_ffv"},   bus.first_fail_vld, 0);
        chk({tag, "_ffi"},   bus.first_fail_idx, 0);
        chk({tag, "_xout"},  x_out, 0);
    endtask

    task automatic load_tbl(input logic [7:0] t);
        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clk);
            bus.tbl_we   = 1'b1;
            bus.tbl_addr = 3'(i);
            bus.tbl_din  = t[i];
        end
        @(negedge clk);
        bus.tbl_we = 1'b0;
        model_tbl  = t;
    endtask

    // One full run. inj_cyc>0: attempt start + table write at that cycle of the run.
    // wr_w_start: table write in the same cycle as start.
    task automatic run(input string tag, input int inj_cyc, input bit wr_w_start,
                       input logic [2:0] wa, input logic wd);
        int  nexp, e_pass, e_fail, e_ffi, cyc, vcnt;
        bit  e_ffv, clr;
        bit  e_mm [8];
        @(negedge clk);
        bus.start = 1'b1;
        if (wr_w_start) begin
            bus.tbl_we    = 1'b1;
            bus.tbl_addr  = wa;
            bus.tbl_din   = wd;
            model_tbl[wa] = wd;
        end
        nexp = 0; e_pass = 0; e_fail = 0; e_ffv = 0; e_ffi = 0;
        for (int v = 0; v < N_VEC; v++) begin
            nexp++;
            e_mm[v] = (dut_tt[v] != model_tbl[v]);
            if (e_mm[v]) begin
                e_fail++;
                if (!e_ffv) begin e_ffv = 1; e_ffi = v; end
            end else begin
                e_pass++;
            end
            if (STOP && e_mm[v]) break;
        end
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.tbl_we = 1'b0;
        cyc = 0; vcnt = 0; clr = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            if (clr) begin bus.start = 1'b0; bus.tbl_we = 1'b0; clr = 0; end
            cyc++;
            if (cyc == 1) chk({tag, "_busy_c1"}, bus.busy, 1);
            if (bus.res_valid) begin
                chk({tag, "_strobe_time"}, cyc, LAT * (vcnt + 1));
                chk({tag, "_res_idx"}, bus.res_idx, vcnt);
                chk({tag, "_res_got"}, bus.res_got, dut_tt[vcnt]);
                chk({tag, "_res_exp"}, bus.res_exp, model_tbl[vcnt]);
                chk({tag, "_res_ok"},  bus.res_ok, !e_mm[vcnt]);
                vcnt++;
            end
            if (bus.done) break;
            if (cyc == inj_cyc) begin
                bus.start    = 1'b1;
                bus.tbl_we   = 1'b1;
                bus.tbl_addr = wa;
                bus.tbl_din  = ~model_tbl[wa];
                clr = 1;
            end
        end
        chk({tag, "_done"},     bus.done, 1);
        chk({tag, "_done_cyc"}, cyc, LAT * nexp);
        chk({tag, "_nstrobe"},  vcnt, nexp);
        chk({tag, "_busy_end"}, bus.busy, 0);
        chk({tag, "_pass"},     bus.pass_cnt, e_pass);
        chk({tag, "_fail"},     bus.fail_cnt, e_fail);
        chk({tag, "_ffv"},      bus.first_fail_vld, e_ffv);
        chk({tag, "_ffi"},      bus.first_fail_idx, e_ffi);
        chk({tag, "_xout"},     x_out, nexp - 1);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_done_hold"}, bus.done, 1);
        chk({tag, "_pass_hold"}, bus.pass_cnt, e_pass);
    endtask

    initial begin
        logic [7:0] t, m;
        bus.start    = 1'b0;
        bus.tbl_we   = 1'b0;
        bus.tbl_addr = '0;
        bus.tbl_din  = 1'b0;
        dut_tt       = 8'h00;
        model_tbl    = 8'h00;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Majority function, matching block.
        load_tbl(8'hE8);
        dut_tt = 8'hE8;
        run("maj_ok", 0, 0, 3'd0, 1'b0);

        // Block faulted at X=5 and X=6.
        dut_tt = 8'hE8 ^ 8'h60;
        run("maj_f56", 0, 0, 3'd0, 1'b0);

        // Restart and table write attempted mid-run are ignored.
        dut_tt = 8'hE8;
        run("busy_ign", 10, 0, 3'd3, 1'b0);
        run("busy_clean", 0, 0, 3'd0, 1'b0);

        // Asynchronous reset in the middle of vector 3.
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        chk("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n     = 1'b1;
        model_tbl = 8'h00;
        run("tbl_cleared", 0, 0, 3'd0, 1'b0);
        load_tbl(8'hE8);
        run("post_rst", 0, 0, 3'd0, 1'b0);

        // Single fault at X=2 (sweep continues or stops depending on build).
        dut_tt = 8'hE8 ^ 8'h04;
        run("fault_x2", 0, 0, 3'd0, 1'b0);

        // Table write coincident with start is applied and used.
        dut_tt = 8'hE8;
        run("wr_start", 0, 1, 3'd3, 1'b0);

        for (int it = 0; it < 6; it++) begin
            t = 8'($urandom);
            m = 8'($urandom) & 8'($urandom);
            load_tbl(t);
            dut_tt = t ^ m;
            run("rand", 0, it[0], 3'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
